register_file_param: RTL and testbench
======================================

Name: register_file_param

Overview:
Parametrised CPU general-purpose register file with an accumulator, replacing the fixed 8x8 one-hot-enabled register bank. Registers are binary-addressed on a split bus interface: bus_in, plus bus_out/bus_oe, which the top level turns into the tri-state cpu bus. The highest-index register is the accumulator. It has a private ALU write port and an always-visible bypass output. Adds a registered read path with write-first forwarding, a sequenced clear-all engine with a busy flag, and a sticky access-error flag.

Parameters:
DATA_W, 8, register/bus width in bits (>=1)
NUM_REGS, 8, number of registers including the accumulator (power of 2, >=2)
ADDR_W, $clog2(NUM_REGS), derived localparam, address width; not overridable
ACC_IDX, NUM_REGS-1, derived localparam, index of the accumulator

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
bus_in  in  DATA_W  data from cpu bus for register writes
wr_en  in  1  bus write strobe
wr_addr  in  ADDR_W  bus write target index
rd_en  in  1  bus read strobe
rd_addr  in  ADDR_W  bus read source index
bus_out  out  DATA_W  registered read data to cpu bus
bus_oe  out  1  bus drive enable, registered, aligned with bus_out
acc_in  in  DATA_W  ALU result for accumulator
acc_wr_en  in  1  accumulator ALU write strobe
acc_out  out  DATA_W  accumulator bypass, direct from ACC register
clr_start  in  1  start clear-all sequence
busy  out  1  clear sequence in progress
err  out  1  sticky access error
err_clr  in  1  clear err

Behaviour:
- Reset (reset==0 at posedge): all registers = 0; bus_out = 0; bus_oe = 0; busy = 0; err = 0; FSM = IDLE; clear index = 0. Reset has priority over everything, including mid-clear; a clear sequence is aborted.
- All strobes below act only when busy==0, i.e. the FSM is in IDLE at that edge.
- Bus write: wr_en=1 at posedge -> reg[wr_addr] <= bus_in.
- ALU write: acc_wr_en=1 -> reg[ACC_IDX] <= acc_in.
- Write collision: wr_en=1 with wr_addr==ACC_IDX and acc_wr_en=1 -> acc_in wins and err is set.
- Read latency: exactly 1 cycle. rd_en=1 at edge N -> at N+1, bus_out = reg[rd_addr] and bus_oe = 1.
- rd_en=0 at edge N -> bus_out = 0 and bus_oe = 0 at N+1.
- Read forwarding (write-first): if the same edge writes rd_addr, bus_out takes the winning write data (acc_in beats bus_in for ACC_IDX).
- Simultaneous wr_en and rd_en to different addresses are both performed; this is not an error.
- acc_out: combinational copy of reg[ACC_IDX]; shows a new value the cycle after the write edge.
- Clear FSM, IDLE: clr_start=1 and busy=0 -> CLEAR, index = 0, busy = 1 next cycle. Any strobes sampled on the same edge as clr_start are still executed.
- Clear FSM, CLEAR: each cycle, reg[index] <= 0 and index++. After clearing index NUM_REGS-1 -> IDLE, busy = 0. busy is high for exactly NUM_REGS cycles.
- While busy: clr_start is ignored, with no error.
- While busy: any wr_en, rd_en or acc_wr_en is dropped and sets err; bus_oe = 0.
- Error flag: err is sticky until err_clr=1. If a set condition and err_clr occur on the same edge, set wins.
- Index arithmetic: unsigned ADDR_W-bit values; the last clear index is detected by compare, so there is no wrap-around past NUM_REGS-1.

Test Plan:
1. Reset low 1 cycle, then rd_en with rd_addr=3 -> next cycle bus_out=0x00, bus_oe=1; acc_out=0x00.
2. wr_en, wr_addr=2, bus_in=0xA5, then rd_en, rd_addr=2 -> bus_out=0xA5 one cycle after the read edge. Repeat with DATA_W=16, NUM_REGS=16: write 0xBEEF to r9 and read it back.
3. Same edge: wr_en, wr_addr=5, bus_in=0x3C, and rd_en, rd_addr=5 -> next cycle bus_out=0x3C (forwarded), and reg5 reads 0x3C later.
4. Same edge: wr_en, wr_addr=7, bus_in=0x11, and acc_wr_en, acc_in=0x99 -> acc_out=0x99 and err=1. Then err_clr -> err=0.
5. Fill r0..r7 with 0xFF, pulse clr_start -> busy high exactly 8 cycles. A wr_en to r1 at cycle 3 of busy is dropped and sets err. Afterwards all registers read 0x00.
6. Pulse clr_start, assert reset low at cycle 4 of busy -> next cycle busy=0, FSM=IDLE, all registers = 0, err = 0.

Source files
------------

// File: rtl/register_file_param.sv
// Parametrised general-purpose register file with accumulator, registered bus
// read port with write-first forwarding, sequenced clear-all engine and sticky error.
module register_file_param #(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 8,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] acc_in,
  input  logic              acc_wr_en,
  output logic [DATA_W-1:0] acc_out,
  input  logic              clr_start,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  localparam logic [ADDR_W-1:0] ACC_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_data_p0;
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;
  logic              err_q;
  logic              idle;
  logic              collide;
  logic              busy_hit;

  assign idle     = (state == IDLE);
  assign collide  = idle && wr_en && acc_wr_en && (wr_addr == ACC_IDX);
  assign busy_hit = !idle && (wr_en || rd_en || acc_wr_en);

  // Stage p0: read mux with write-first forwarding; the ALU port beats the bus.
  always_comb begin
    rd_data_p0 = regs[rd_addr];
    if (wr_en && (wr_addr == rd_addr))
      rd_data_p0 = bus_in;
    if (acc_wr_en && (rd_addr == ACC_IDX))
      rd_data_p0 = acc_in;
  end

  // Stage p1: register array, read register, clear sequencer and error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
      state      <= IDLE;
      clr_idx    <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_data_p1 <= '0;
      vld_p1     <= 1'b0;
      err_q      <= collide || busy_hit || (err_q && !err_clr);
      case (state)
        IDLE: begin
          if (wr_en)
            regs[wr_addr] <= bus_in;
          if (acc_wr_en)
            regs[ACC_IDX] <= acc_in;
          if (rd_en) begin
            rd_data_p1 <= rd_data_p0;
            vld_p1     <= 1'b1;
          end
          if (clr_start) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end
        end
        CLEAR: begin
          regs[clr_idx] <= '0;
          if (clr_idx == ACC_IDX) begin
            state   <= IDLE;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_out = rd_data_p1;
  assign bus_oe  = vld_p1;
  assign acc_out = regs[ACC_IDX];
  assign busy    = (state == CLEAR);
  assign err     = err_q;

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: an 8x8 instance tracked by a cycle-level model
// plus a 16x16 instance exercised with directed vectors.
module tb_register_file_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] bus_in, bus_out, acc_in, acc_out;
  logic [2:0] wr_addr, rd_addr;
  logic       wr_en, rd_en, acc_wr_en, clr_start, err_clr, bus_oe, busy, err;

  logic [15:0] b_bus_in, b_bus_out, b_acc_in, b_acc_out;
  logic [3:0]  b_wr_addr, b_rd_addr;
  logic        b_wr_en, b_rd_en, b_acc_wr_en, b_clr_start, b_err_clr, b_bus_oe, b_busy, b_err;

  register_file_param #(.DATA_W(8), .NUM_REGS(8)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .bus_out(bus_out), .bus_oe(bus_oe),
    .acc_in(acc_in), .acc_wr_en(acc_wr_en), .acc_out(acc_out),
    .clr_start(clr_start), .busy(busy), .err(err), .err_clr(err_clr)
  );

  register_file_param #(.DATA_W(16), .NUM_REGS(16)) dut16 (
    .clk(clk), .reset(reset), .bus_in(b_bus_in), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .bus_out(b_bus_out), .bus_oe(b_bus_oe),
    .acc_in(b_acc_in), .acc_wr_en(b_acc_wr_en), .acc_out(b_acc_out),
    .clr_start(b_clr_start), .busy(b_busy), .err(b_err), .err_clr(b_err_clr)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the 8x8 instance: register contents, clear countdown, expected outputs.
  logic [7:0] m_regs [8];
  logic [7:0] m_out = '0;
  logic       m_oe = 1'b0;
  logic       m_err = 1'b0;
  int         m_left = 0;
  logic       m_on = 1'b0;

  always @(posedge clk) begin
    m_on = 1'b1;
    if (!reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_out = '0; m_oe = 1'b0; m_err = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      m_regs[8 - m_left] = '0;
      m_left = m_left - 1;
      m_out = '0; m_oe = 1'b0;
      m_err = wr_en || rd_en || acc_wr_en || (m_err && !err_clr);
    end else begin
      m_err = (wr_en && acc_wr_en && wr_addr == 3'd7) || (m_err && !err_clr);
      if (wr_en) m_regs[wr_addr] = bus_in;
      if (acc_wr_en) m_regs[7] = acc_in;
      m_oe = rd_en;
      m_out = rd_en ? m_regs[rd_addr] : 8'h00;
      if (clr_start) m_left = 8;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("bus_out", bus_out, m_out);
      check("bus_oe", bus_oe, m_oe);
      check("acc_out", acc_out, m_regs[7]);
      check("busy", busy, m_left > 0);
      check("err", err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_a();
    wr_en = 0; rd_en = 0; acc_wr_en = 0; clr_start = 0; err_clr = 0;
  endtask

  task automatic rd_a(input int a);
    idle_a(); rd_en = 1; rd_addr = 3'(a); tick(); idle_a();
  endtask

  task automatic wr_a(input int a, input logic [7:0] d);
    idle_a(); wr_en = 1; wr_addr = 3'(a); bus_in = d; tick(); idle_a();
  endtask

  int cyc;

  initial begin
    idle_a(); bus_in = 0; wr_addr = 0; rd_addr = 0; acc_in = 0;
    b_bus_in = 0; b_wr_addr = 0; b_rd_addr = 0; b_acc_in = 0;
    b_wr_en = 0; b_rd_en = 0; b_acc_wr_en = 0; b_clr_start = 0; b_err_clr = 0;
    reset = 0;
    tick();
    reset = 1;
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_oe", bus_oe, 0);

    // Test 1: read after reset
    rd_a(3);
    check("t1_bus_out", bus_out, 8'h00);
    check("t1_bus_oe", bus_oe, 1);
    check("t1_acc_out", acc_out, 8'h00);

    // Test 2: write/read, both widths
    wr_a(2, 8'hA5);
    rd_a(2);
    check("t2_bus_out", bus_out, 8'hA5);
    b_wr_en = 1; b_wr_addr = 4'd9; b_bus_in = 16'hBEEF; tick(); b_wr_en = 0;
    b_rd_en = 1; b_rd_addr = 4'd9; tick(); b_rd_en = 0;
    check("t2_w16_out", b_bus_out, 16'hBEEF);
    check("t2_w16_oe", b_bus_oe, 1);
    b_acc_wr_en = 1; b_acc_in = 16'h1234; tick(); b_acc_wr_en = 0;
    check("t2_w16_acc", b_acc_out, 16'h1234);

    // Test 3: forwarding on same-edge write and read
    idle_a(); wr_en = 1; wr_addr = 5; bus_in = 8'h3C; rd_en = 1; rd_addr = 5; tick(); idle_a();
    check("t3_fwd", bus_out, 8'h3C);
    tick();
    check("t3_idle_oe", bus_oe, 0);
    check("t3_idle_out", bus_out, 8'h00);
    rd_a(5);
    check("t3_reread", bus_out, 8'h3C);

    // Test 4: collision on accumulator, forwarded read of ACC, err handling
    idle_a(); wr_en = 1; wr_addr = 7; bus_in = 8'h11; acc_wr_en = 1; acc_in = 8'h99;
    rd_en = 1; rd_addr = 7; tick(); idle_a();
    check("t4_acc", acc_out, 8'h99);
    check("t4_err", err, 1);
    check("t4_fwd_acc", bus_out, 8'h99);
    err_clr = 1; tick(); idle_a();
    check("t4_err_clr", err, 0);
    wr_en = 1; wr_addr = 7; acc_wr_en = 1; acc_in = 8'h5A; err_clr = 1; tick(); idle_a();
    check("t4_set_wins", err, 1);
    err_clr = 1; tick(); idle_a();
    check("t4_err_clr2", err, 0);

    // Test 5: fill, clear-all, dropped strobes while busy
    for (int i = 0; i < 8; i++) wr_a(i, 8'hFF);
    clr_start = 1; tick(); idle_a();
    cyc = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      cyc++;
      idle_a();
      if (cyc == 3) begin wr_en = 1; wr_addr = 1; bus_in = 8'h55; rd_en = 1; rd_addr = 0; end
      if (cyc == 5) clr_start = 1;
      tick();
    end
    idle_a();
    check("t5_busy_len", cyc, 8);
    check("t5_err", err, 1);
    err_clr = 1; tick(); idle_a();
    for (int i = 0; i < 8; i++) begin
      rd_a(i);
      check("t5_cleared", bus_out, 8'h00);
    end

    // Test 6: reset in the middle of a clear
    wr_a(3, 8'h77);
    wr_en = 1; wr_addr = 7; acc_wr_en = 1; acc_in = 8'h42; tick(); idle_a();
    check("t6_pre_err", err, 1);
    clr_start = 1; tick(); idle_a();
    cyc = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      cyc++;
      if (cyc == 4) reset = 0;
      tick();
      if (cyc == 4) begin reset = 1; break; end
    end
    check("t6_busy", busy, 0);
    check("t6_err", err, 0);
    check("t6_acc", acc_out, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rd_a(i);
      check("t6_zero", bus_out, 8'h00);
    end
    rd_a(7);
    check("t6_oe", bus_oe, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
